cordic_bus_slave: RTL and testbench
===================================

Name: cordic_bus_slave

Overview:
- Bus-side endpoint of the CORDIC controller link: a memory-mapped register slave that drives the controller's operand and control inputs and returns its results.
- Converts simple single-cycle host writes and one-cycle-latency host reads into the controller-side signals xInput/yInput/zInput/controlRegisterInput.
- Captures xResult/yResult/zResult into a coherent snapshot on each controller interrupt.
- Owns interrupt pending/enable state and the masked merge of controller-owned control bits.

Parameters:
- p_WIDTH, 32, data width of every operand, result and control register; also the host data width.
- p_ADDR_WIDTH, 4, host word-address width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- busAddr  input  p_ADDR_WIDTH  host word address.
- busWrEn  input  1  host write strobe, one cycle per write.
- busWrData  input  p_WIDTH  host write data.
- busRdEn  input  1  host read strobe.
- busRdData  output  p_WIDTH  read data, valid when busRdValid=1.
- busRdValid  output  1  read-data qualifier.
- busRdErr  output  1  qualifies busRdValid; high when the read address is unmapped.
- irq  output  1  host interrupt request.
- xInput, yInput, zInput  output  p_WIDTH (signed)  operands to the controller.
- controlRegisterInput  output  p_WIDTH  control word to the controller.
- xResult, yResult, zResult  input  p_WIDTH (signed)  controller results.
- controlRegisterOutput  input  p_WIDTH  controller-driven control bits.
- controlRegisterMask  input  p_WIDTH  1 = bit is owned by the controller.
- interrupt  input  1  controller completion level.

Behaviour:
- Reset values:
  - Operand, control, snapshot, pending and enable registers are all 0.
  - busRdData=0, busRdValid=0, busRdErr=0, irq=0.
  - The registered copy of interrupt (intPrev) is 0.
- Address map:
  - 0 X_IN (RW), 1 Y_IN (RW), 2 Z_IN (RW), 3 CTRL (RW, masked).
  - 4 X_RES (RO snapshot), 5 Y_RES (RO), 6 Z_RES (RO).
  - 7 IRQ_STATUS: bit0 pending, write 1 to clear.
  - 8 IRQ_ENABLE: bit0, RW.
  - Other addresses: reads return 0 with busRdErr=1; writes are ignored.
  - Writes to read-only addresses are ignored with no error.
- Writes: a write in cycle N updates the register at the edge ending N; the outputs driven from it change in N+1.
- Operand outputs are the X_IN/Y_IN/Z_IN registers directly, with no extra pipeline stage.
- CTRL register, updated every cycle:
  - Next value = (busWrite ? busWrData : ctrl) & ~controlRegisterMask | controlRegisterOutput & controlRegisterMask.
  - A host write never changes mask=1 bits.
  - The controller's value is tracked continuously in mask=1 bits.
  - controlRegisterInput = ctrl.
- Reads:
  - busRdEn in cycle N gives busRdData and busRdValid=1 for exactly cycle N+1; busRdValid is otherwise 0.
  - busRdData holds its last value when busRdValid=0.
  - A CTRL read returns the merged register.
- Read and write to the same address in the same cycle: the read returns the pre-write value.
- Interrupt detection: rising edge is interrupt & ~intPrev.
- On a rising edge:
  - Snapshot registers capture xResult/yResult/zResult.
  - pending is set.
- A level held high does not re-trigger.
- Set and clear of pending in the same cycle: set wins, so pending stays 1.
- A snapshot capture and a read of X_RES in the same cycle: the read returns the pre-capture value.
- irq = pending & enable, registered, so irq lags the interrupt edge by 2 cycles: pending in N+1, irq in N+2.
- Setting enable while pending=1 raises irq on the following cycle.
- Reset mid-operation:
  - All state returns to reset values on the next edge.
  - A read issued in the reset cycle produces no busRdValid.
  - intPrev clears, so an interrupt line still high after reset counts as a new edge.
- Width: all registers are p_WIDTH; no sign extension or arithmetic; unused upper bits of IRQ registers read 0.

Decomposition:
- Package cordic_bus_pkg:
  - address constants c_ADDR_X_IN … c_ADDR_IRQ_EN;
  - bit index c_IRQ_PENDING_BIT = 0;
  - typedef for the address enum.
- One sub-module, cordic_irq_ctrl:
  - edge detector, pending/enable registers and irq register;
  - outputs captureStrobe to the snapshot registers.
- Register file and read mux stay in the top level.

Test Plan:
1. Reset, then write 0x00010000 to addr 0, 0xFFFF0000 to addr 1 and 0x5 to addr 2, each read back.
   Required: xInput/yInput/zInput equal the written values one cycle after each write; reads return them with 1-cycle latency.
2. controlRegisterMask=0x0000FF00, controlRegisterOutput=0x0000AB00, host writes 0xFFFFFFFF to CTRL.
   Required: controlRegisterInput=0xFFFFABFF and CTRL reads back 0xFFFFABFF.
3. Enable=1, xResult=0x1234, interrupt pulses high for 3 cycles, then xResult changes to 0x9999.
   Required: X_RES reads 0x1234, pending=1, irq=1 two cycles after the edge, and only one capture occurs.
4. Write 1 to IRQ_STATUS in the same cycle as a new interrupt edge.
   Required: pending remains 1; a later W1C with no edge clears it and irq drops the next cycle.
5. Read addr 0xF.
   Required: busRdData=0 and busRdErr=1 with busRdValid; a write to 0xF changes nothing.
6. Assert rst mid-read with busRdEn=1 and pending=1.
   Required: no busRdValid, all outputs 0, irq=0 next cycle.

Source files
------------

// File: rtl/cordic_bus_pkg.sv
// Shared address map and bit positions for the CORDIC bus slave.
// Pure declarations, no logic.
// Imported by the register file and the interrupt controller.
package cordic_bus_pkg;

    // Host word addresses of the register map
    typedef enum int unsigned {
        c_ADDR_X_IN   = 0,
        c_ADDR_Y_IN   = 1,
        c_ADDR_Z_IN   = 2,
        c_ADDR_CTRL   = 3,
        c_ADDR_X_RES  = 4,
        c_ADDR_Y_RES  = 5,
        c_ADDR_Z_RES  = 6,
        c_ADDR_IRQ_ST = 7,
        c_ADDR_IRQ_EN = 8
    } cordic_addr_e;

    // Bit carrying pending in IRQ_STATUS and enable in IRQ_ENABLE
    localparam int c_IRQ_PENDING_BIT = 0;

endpackage

// File: rtl/cordic_irq_ctrl.sv
// Interrupt edge detection, pending/enable state and the registered irq line.
// captureStrobe is combinational in the edge cycle; pending N+1, irq N+2.
// No backpressure: a clear in the same cycle as a new edge loses to the set.
module cordic_irq_ctrl (
    input  logic clk,
    input  logic rst,
    input  logic interrupt,
    input  logic statusWrEn,
    input  logic statusWrData,
    input  logic enableWrEn,
    input  logic enableWrData,
    output logic captureStrobe,
    output logic pending,
    output logic enable,
    output logic irq
);

    logic int_prev_q;
    logic pending_q, pending_d;
    logic enable_q;
    logic irq_q;

    assign captureStrobe = interrupt & ~int_prev_q;

    // Set on a rising edge; write-1-to-clear only takes effect without a concurrent edge
    always_comb begin
        pending_d = pending_q;
        if (statusWrEn && statusWrData) begin
            pending_d = 1'b0;
        end
        if (captureStrobe) begin
            pending_d = 1'b1;
        end
    end

    // Edge history, pending/enable state and the registered irq request
    always_ff @(posedge clk) begin
        if (rst) begin
            int_prev_q <= 1'b0;
            pending_q  <= 1'b0;
            enable_q   <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            int_prev_q <= interrupt;
            pending_q  <= pending_d;
            if (enableWrEn) begin
                enable_q <= enableWrData;
            end
            irq_q <= pending_q & enable_q;
        end
    end

    assign pending = pending_q;
    assign enable  = enable_q;
    assign irq     = irq_q;

endmodule

// File: rtl/cordic_bus_slave.sv
// Host register slave feeding operands/control to the CORDIC controller and returning results.
// Writes visible next cycle; reads return data one cycle after busRdEn.
// No backpressure: every strobe is accepted in the cycle it is presented.
module cordic_bus_slave
    import cordic_bus_pkg::*;
#(
    parameter int p_WIDTH      = 32,
    parameter int p_ADDR_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [p_ADDR_WIDTH-1:0]   busAddr,
    input  logic                      busWrEn,
    input  logic [p_WIDTH-1:0]        busWrData,
    input  logic                      busRdEn,
    output logic [p_WIDTH-1:0]        busRdData,
    output logic                      busRdValid,
    output logic                      busRdErr,
    output logic                      irq,
    output logic signed [p_WIDTH-1:0] xInput,
    output logic signed [p_WIDTH-1:0] yInput,
    output logic signed [p_WIDTH-1:0] zInput,
    output logic [p_WIDTH-1:0]        controlRegisterInput,
    input  logic signed [p_WIDTH-1:0] xResult,
    input  logic signed [p_WIDTH-1:0] yResult,
    input  logic signed [p_WIDTH-1:0] zResult,
    input  logic [p_WIDTH-1:0]        controlRegisterOutput,
    input  logic [p_WIDTH-1:0]        controlRegisterMask,
    input  logic                      interrupt
);

    logic [31:0]        addr;
    logic [p_WIDTH-1:0] x_q, y_q, z_q;
    logic [p_WIDTH-1:0] ctrl_q, ctrl_d, ctrl_base;
    logic [p_WIDTH-1:0] xres_q, yres_q, zres_q;
    logic [p_WIDTH-1:0] rd_data_q, rd_data_d;
    logic               rd_vld_q, rd_err_q, rd_err_d;
    logic               wr_x, wr_y, wr_z, wr_ctrl, wr_irq_st, wr_irq_en;
    logic               capture_strobe, pending, enable;

    assign addr = 32'(busAddr);

    // Write decode; read-only and unmapped addresses simply match nothing
    always_comb begin
        wr_x      = busWrEn && (addr == c_ADDR_X_IN);
        wr_y      = busWrEn && (addr == c_ADDR_Y_IN);
        wr_z      = busWrEn && (addr == c_ADDR_Z_IN);
        wr_ctrl   = busWrEn && (addr == c_ADDR_CTRL);
        wr_irq_st = busWrEn && (addr == c_ADDR_IRQ_ST);
        wr_irq_en = busWrEn && (addr == c_ADDR_IRQ_EN);
    end

    // Controller-owned bits always follow the controller; host only reaches unmasked bits
    always_comb begin
        ctrl_base = wr_ctrl ? busWrData : ctrl_q;
        ctrl_d    = (ctrl_base & ~controlRegisterMask)
                  | (controlRegisterOutput & controlRegisterMask);
    end

    // Read mux sees pre-edge state, so same-cycle writes/captures are not visible
    always_comb begin
        rd_data_d = '0;
        rd_err_d  = 1'b0;
        case (addr)
            c_ADDR_X_IN:   rd_data_d = x_q;
            c_ADDR_Y_IN:   rd_data_d = y_q;
            c_ADDR_Z_IN:   rd_data_d = z_q;
            c_ADDR_CTRL:   rd_data_d = ctrl_q;
            c_ADDR_X_RES:  rd_data_d = xres_q;
            c_ADDR_Y_RES:  rd_data_d = yres_q;
            c_ADDR_Z_RES:  rd_data_d = zres_q;
            c_ADDR_IRQ_ST: rd_data_d = {{(p_WIDTH-1){1'b0}}, pending};
            c_ADDR_IRQ_EN: rd_data_d = {{(p_WIDTH-1){1'b0}}, enable};
            default:       rd_err_d  = 1'b1;
        endcase
    end

    cordic_irq_ctrl u_irq (
        .clk           (clk),
        .rst           (rst),
        .interrupt     (interrupt),
        .statusWrEn    (wr_irq_st),
        .statusWrData  (busWrData[c_IRQ_PENDING_BIT]),
        .enableWrEn    (wr_irq_en),
        .enableWrData  (busWrData[c_IRQ_PENDING_BIT]),
        .captureStrobe (capture_strobe),
        .pending       (pending),
        .enable        (enable),
        .irq           (irq)
    );

    // Operand, control and result-snapshot registers
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q    <= '0;
            y_q    <= '0;
            z_q    <= '0;
            ctrl_q <= '0;
            xres_q <= '0;
            yres_q <= '0;
            zres_q <= '0;
        end else begin
            if (wr_x) x_q <= busWrData;
            if (wr_y) y_q <= busWrData;
            if (wr_z) z_q <= busWrData;
            ctrl_q <= ctrl_d;
            if (capture_strobe) begin
                xres_q <= xResult;
                yres_q <= yResult;
                zres_q <= zResult;
            end
        end
    end

    // Read response: one-cycle valid pulse, data held between reads
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
            rd_vld_q  <= 1'b0;
            rd_err_q  <= 1'b0;
        end else begin
            rd_vld_q <= busRdEn;
            rd_err_q <= busRdEn & rd_err_d;
            if (busRdEn) begin
                rd_data_q <= rd_data_d;
            end
        end
    end

    assign xInput               = x_q;
    assign yInput               = y_q;
    assign zInput               = z_q;
    assign controlRegisterInput = ctrl_q;
    assign busRdData            = rd_data_q;
    assign busRdValid           = rd_vld_q;
    assign busRdErr             = rd_err_q;

endmodule

// File: tb/tb_cordic_bus_slave.sv
// Scoreboard bench for cordic_bus_slave: directed scenarios followed by random traffic.
// Expected read responses are queued at issue time and popped by a monitor on busRdValid.
// Level outputs are compared against a register-map model after every cycle.
module tb_cordic_bus_slave;

    logic               clk = 1'b0;
    logic               rst;
    logic [3:0]         busAddr;
    logic               busWrEn;
    logic [31:0]        busWrData;
    logic               busRdEn;
    logic [31:0]        busRdData;
    logic               busRdValid;
    logic               busRdErr;
    logic               irq;
    logic signed [31:0] xInput, yInput, zInput;
    logic [31:0]        controlRegisterInput;
    logic signed [31:0] xResult, yResult, zResult;
    logic [31:0]        cro, mask;
    logic               interrupt;

    int total = 0;
    int bad   = 0;

    // Model of the register map
    logic [31:0] m_x, m_y, m_z, m_ctrl, m_xr, m_yr, m_zr, m_rd;
    logic        m_pend, m_en, m_irq, m_prev, m_vld;
    logic [32:0] exp_q[$];

    cordic_bus_slave #(.p_WIDTH(32), .p_ADDR_WIDTH(4)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .busAddr               (busAddr),
        .busWrEn               (busWrEn),
        .busWrData             (busWrData),
        .busRdEn               (busRdEn),
        .busRdData             (busRdData),
        .busRdValid            (busRdValid),
        .busRdErr              (busRdErr),
        .irq                   (irq),
        .xInput                (xInput),
        .yInput                (yInput),
        .zInput                (zInput),
        .controlRegisterInput  (controlRegisterInput),
        .xResult               (xResult),
        .yResult               (yResult),
        .zResult               (zResult),
        .controlRegisterOutput (cro),
        .controlRegisterMask   (mask),
        .interrupt             (interrupt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // {err, data} the host should see for a read of address a right now
    function automatic logic [32:0] model_read(input logic [3:0] a);
        case (a)
            4'd0:    return {1'b0, m_x};
            4'd1:    return {1'b0, m_y};
            4'd2:    return {1'b0, m_z};
            4'd3:    return {1'b0, m_ctrl};
            4'd4:    return {1'b0, m_xr};
            4'd5:    return {1'b0, m_yr};
            4'd6:    return {1'b0, m_zr};
            4'd7:    return {1'b0, 31'd0, m_pend};
            4'd8:    return {1'b0, 31'd0, m_en};
            default: return {1'b1, 32'd0};
        endcase
    endfunction

    // Monitor: every presented read response must match the oldest queued expectation
    initial begin
        logic [32:0] e;
        forever begin
            @(negedge clk);
            if (busRdValid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rd_valid", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rd_data", busRdData, e[31:0]);
                    chk("rd_err", {31'd0, busRdErr}, {31'd0, e[32]});
                end
            end
        end
    end

    // Advance one clock: update the model from the current inputs, then compare levels
    task automatic step();
        logic [32:0] r;
        logic        rise, n_pend, n_irq;
        logic [31:0] base;
        if (rst) begin
            {m_x, m_y, m_z, m_ctrl, m_xr, m_yr, m_zr, m_rd} = '0;
            {m_pend, m_en, m_irq, m_prev, m_vld} = '0;
        end else begin
            if (busRdEn) begin
                r = model_read(busAddr);
                exp_q.push_back(r);
                m_rd = r[31:0];
            end
            m_vld  = busRdEn;
            rise   = interrupt && !m_prev;
            n_irq  = m_pend && m_en;
            n_pend = rise || (m_pend && !(busWrEn && busAddr == 4'd7 && busWrData[0]));
            base   = (busWrEn && busAddr == 4'd3) ? busWrData : m_ctrl;
            m_ctrl = (base & ~mask) | (cro & mask);
            if (busWrEn) begin
                case (busAddr)
                    4'd0: m_x = busWrData;
                    4'd1: m_y = busWrData;
                    4'd2: m_z = busWrData;
                    4'd8: m_en = busWrData[0];
                    default: ;
                endcase
            end
            if (rise) begin
                m_xr = xResult;
                m_yr = yResult;
                m_zr = zResult;
            end
            m_pend = n_pend;
            m_irq  = n_irq;
            m_prev = interrupt;
        end
        @(posedge clk);
        @(negedge clk);
        chk("xInput", xInput, m_x);
        chk("yInput", yInput, m_y);
        chk("zInput", zInput, m_z);
        chk("ctrl_in", controlRegisterInput, m_ctrl);
        chk("irq", {31'd0, irq}, {31'd0, m_irq});
        chk("rd_valid", {31'd0, busRdValid}, {31'd0, m_vld});
        chk("rd_data_hold", busRdData, m_rd);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        busWrEn = 1'b1; busAddr = a; busWrData = d;
        step();
        busWrEn = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a);
        busRdEn = 1'b1; busAddr = a;
        step();
        busRdEn = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst = 1'b1; busAddr = '0; busWrEn = 1'b0; busWrData = '0; busRdEn = 1'b0;
        xResult = '0; yResult = '0; zResult = '0; cro = '0; mask = '0; interrupt = 1'b0;
        @(negedge clk);
        idle(2);
        chk("reset_rd_err", {31'd0, busRdErr}, 32'd0);
        rst = 1'b0;

        // Operand writes and read-back
        wr(4'd0, 32'h0001_0000); rd(4'd0);
        wr(4'd1, 32'hFFFF_0000); rd(4'd1);
        wr(4'd2, 32'h0000_0005); rd(4'd2);
        // Same-cycle read and write returns the old value
        busWrEn = 1'b1; busRdEn = 1'b1; busAddr = 4'd0; busWrData = 32'hCAFE_F00D;
        step();
        busWrEn = 1'b0; busRdEn = 1'b0;
        rd(4'd0);

        // Masked control merge
        mask = 32'h0000_FF00; cro = 32'h0000_AB00;
        wr(4'd3, 32'hFFFF_FFFF);
        chk("ctrl_merge", controlRegisterInput, 32'hFFFF_ABFF);
        rd(4'd3);

        // Interrupt held 3 cycles captures once
        wr(4'd8, 32'd1);
        xResult = 32'h1234; yResult = 32'h55; zResult = -32'sd7;
        interrupt = 1'b1;
        idle(3);
        interrupt = 1'b0; xResult = 32'h9999;
        idle(1);
        rd(4'd4); rd(4'd5); rd(4'd6); rd(4'd7);
        chk("irq_after_edge", {31'd0, irq}, 32'd1);

        // Clear racing a new edge: set wins, then a plain clear drops irq
        interrupt = 1'b1; busWrEn = 1'b1; busAddr = 4'd7; busWrData = 32'd1;
        step();
        busWrEn = 1'b0;
        rd(4'd7);
        interrupt = 1'b0;
        wr(4'd7, 32'd1);
        rd(4'd7);
        idle(2);
        chk("irq_cleared", {31'd0, irq}, 32'd0);

        // Unmapped address
        rd(4'hF);
        wr(4'hF, 32'hDEAD_BEEF);
        wr(4'd4, 32'hDEAD_BEEF);
        rd(4'd4);

        // Reset during a read with pending set; line stays high across reset
        interrupt = 1'b1;
        idle(3);
        rst = 1'b1; busRdEn = 1'b1; busAddr = 4'd0;
        step();
        chk("rst_rd_err", {31'd0, busRdErr}, 32'd0);
        rst = 1'b0; busRdEn = 1'b0;
        wr(4'd8, 32'd1);
        idle(2);
        rd(4'd7);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            if (i % 50 == 0) begin
                mask = $urandom; cro = $urandom;
            end
            if ($urandom_range(0, 7) == 0) cro = $urandom;
            rst       = ($urandom_range(0, 79) == 0);
            busWrEn   = ($urandom_range(0, 2) == 0);
            busRdEn   = ($urandom_range(0, 1) == 0);
            busAddr   = 4'($urandom_range(0, 15));
            busWrData = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 1)) : $urandom;
            xResult   = $urandom; yResult = $urandom; zResult = $urandom;
            if ($urandom_range(0, 3) == 0) interrupt = ~interrupt;
            step();
        end
        rst = 1'b0; busWrEn = 1'b0; busRdEn = 1'b0;
        idle(3);
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
